// File: rtl/btn_value_counter_pkg.sv
// Shared constants and helpers for the button-driven display value counter.
// Autorepeat support is selected with BTN_AUTOREPEAT_EN (see btn_debounce).
package btn_value_counter_pkg;

   localparam int MAX_DIGIT_VALUE = 15;
   localparam int DISP_WIDTH      = 4;

   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_UP   = 2'd1,
      CNT_DN   = 2'd2,
      CNT_CLR  = 2'd3
   } cnt_op_e;

   // Width able to hold 0..cycles-1, never less than one bit.
   function automatic int deb_cnt_w(input int cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/btn_value_counter_if.sv
// Button/clear inputs and value/wrap outputs of the display value counter.
interface btn_value_counter_if
   import btn_value_counter_pkg::*;
#(
   parameter int WIDTH = DISP_WIDTH
);
   logic             btn_up;
   logic             btn_dn;
   logic             clr;
   logic [WIDTH-1:0] value;
   logic             wrap;

   modport master (output btn_up, output btn_dn, output clr, input value, input wrap);
   modport slave  (input btn_up, input btn_dn, input clr, output value, output wrap);
endinterface

// File: rtl/btn_debounce.sv
// Synchroniser, debouncer and press-edge pulse for one raw button.
// With BTN_AUTOREPEAT_EN defined, a held button also emits periodic repeat pulses.
module btn_debounce
   import btn_value_counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_CYCLES   = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   input  logic clr_i,
   output logic press_o
);
   localparam int            CW       = deb_cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d, level_dly_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          edge_w;

   // Any sample equal to the stable level restarts the mismatch window.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) level_d = sync2_q;
         else                   cnt_d   = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         sync1_q     <= btn_i;
         sync2_q     <= sync1_q;
         level_q     <= level_d;
         level_dly_q <= level_q;
         cnt_q       <= cnt_d;
      end
   end

   assign edge_w = level_q & ~level_dly_q;

`ifdef BTN_AUTOREPEAT_EN
   localparam int            RW       = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES);

   logic [RW-1:0] rep_q, rep_d;
   logic          rep_hit;

   // rep_q counts cycles since the last pulse; reload to 1 keeps the period exact.
   assign rep_hit = level_q & (rep_q == REP_LAST);

   always_comb begin
      rep_d = rep_q + 1'b1;
      if (!level_q || clr_i) rep_d = '0;
      else if (rep_hit)      rep_d = RW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rep_q <= '0;
      else        rep_q <= rep_d;
   end

   assign press_o = edge_w | rep_hit;
`else
   localparam int unused_repeat_cycles = REPEAT_CYCLES;
   logic unused_clr;
   assign unused_clr = clr_i;
   assign press_o    = edge_w;
`endif

endmodule

// File: rtl/btn_value_counter.sv
// Up/down modulo counter driven by two debounced buttons, feeding the display splitter.
// Optional autorepeat is enabled by defining BTN_AUTOREPEAT_EN.
module btn_value_counter
   import btn_value_counter_pkg::*;
#(
   parameter int WIDTH           = DISP_WIDTH,
   parameter int MAX             = MAX_DIGIT_VALUE,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_CYCLES   = 8
) (
   input logic                clk,
   input logic                rst_n,
   btn_value_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic             up_pulse, dn_pulse;
   logic [WIDTH-1:0] value_q, value_d;
   logic             wrap_q, wrap_d;
   cnt_op_e          op;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) u_up (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (bus.btn_up),
      .clr_i   (bus.clr),
      .press_o (up_pulse)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) u_dn (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (bus.btn_dn),
      .clr_i   (bus.clr),
      .press_o (dn_pulse)
   );

   // Clear dominates; simultaneous up and down pulses cancel.
   always_comb begin
      op = CNT_HOLD;
      if (bus.clr)                   op = CNT_CLR;
      else if (up_pulse && !dn_pulse) op = CNT_UP;
      else if (dn_pulse && !up_pulse) op = CNT_DN;
   end

   // Compare against MAX before adding so MAX = 2^WIDTH-1 never overflows.
   always_comb begin
      value_d = value_q;
      wrap_d  = 1'b0;
      case (op)
         CNT_CLR: value_d = '0;
         CNT_UP: begin
            if (value_q == MAX_V) begin
               value_d = '0;
               wrap_d  = 1'b1;
            end else begin
               value_d = value_q + 1'b1;
            end
         end
         CNT_DN: begin
            if (value_q == '0) begin
               value_d = MAX_V;
               wrap_d  = 1'b1;
            end else begin
               value_d = value_q - 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         value_q <= value_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.value = value_q;
   assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_btn_value_counter.sv
// Directed bench for btn_value_counter: a MAX=15 instance and a MAX=9 instance.
module tb_btn_value_counter;
   localparam int DEB = 4;
   localparam int REP = 8;
`ifdef BTN_AUTOREPEAT_EN
   localparam int HOLD = 8;
`else
   localparam int HOLD = 20;
`endif

   typedef struct {
      logic [3:0] value;
      logic       wrap;
      int         lat;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   m [2]    = '{0, 0};
   int   maxv [2] = '{15, 9};
   exp_t sb [$];

   btn_value_counter_if #(.WIDTH(4)) bus ();
   btn_value_counter_if #(.WIDTH(4)) bus9 ();

   btn_value_counter #(.WIDTH(4), .MAX(15), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   btn_value_counter #(.WIDTH(4), .MAX(9), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)) u_dut9 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus9)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] cur_val(input bit d9);
      return d9 ? bus9.value : bus.value;
   endfunction

   function automatic logic cur_wrap(input bit d9);
      return d9 ? bus9.wrap : bus.wrap;
   endfunction

   task automatic set_btn(input bit d9, input logic up, input logic dn);
      if (d9) begin
         bus9.btn_up = up;
         bus9.btn_dn = dn;
      end else begin
         bus.btn_up = up;
         bus.btn_dn = dn;
      end
   endtask

   // Waits (bounded) for the value to move, then scores it against the queue head.
   task automatic wait_change(input bit d9, input string tag, output int n);
      exp_t       e;
      logic [3:0] prev;
      prev = cur_val(d9);
      n = 0;
      while (cur_val(d9) === prev && n < 40) begin
         step();
         n++;
      end
      e = sb.pop_front();
      chk({tag, "_value"}, cur_val(d9), e.value);
      chk({tag, "_wrap"}, cur_wrap(d9), e.wrap);
      chk({tag, "_latency"}, n, e.lat);
   endtask

   task automatic push_press(input bit d9, input bit up);
      exp_t e;
      if (up) begin
         e.wrap  = (m[d9] == maxv[d9]);
         e.value = e.wrap ? 4'd0 : 4'(m[d9] + 1);
      end else begin
         e.wrap  = (m[d9] == 0);
         e.value = e.wrap ? 4'(maxv[d9]) : 4'(m[d9] - 1);
      end
      e.lat = DEB + 3;
      sb.push_back(e);
      m[d9] = int'(e.value);
   endtask

   task automatic press(input bit d9, input bit up, input string tag);
      int n;
      @(negedge clk);
      set_btn(d9, up, !up);
      push_press(d9, up);
      wait_change(d9, tag, n);
      step();
      n++;
      chk({tag, "_wrap_one_cycle"}, cur_wrap(d9), 0);
      repeat (HOLD - n) step();
      chk({tag, "_held"}, cur_val(d9), m[d9]);
      @(negedge clk);
      set_btn(d9, 1'b0, 1'b0);
      repeat (DEB + 4) step();
      chk({tag, "_released"}, cur_val(d9), m[d9]);
   endtask

   initial begin
      int n;
      int bad;
      set_btn(0, 1'b0, 1'b0);
      set_btn(1, 1'b0, 1'b0);
      bus.clr  = 1'b0;
      bus9.clr = 1'b0;

      // reset state
      repeat (2) step();
      chk("reset_value", bus.value, 0);
      chk("reset_wrap", bus.wrap, 0);
      chk("reset_value9", bus9.value, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();
      chk("idle_value", bus.value, 0);

      // clean presses
      press(0, 1'b1, "clean1");
      press(0, 1'b1, "clean2");

      // bounce: toggling every 2 cycles is never accepted
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bus.btn_up = ((i / 2) % 2 == 0);
         @(posedge clk);
         #1;
         if (bus.value !== 4'(m[0]) || bus.wrap !== 1'b0) bad++;
      end
      chk("bounce_no_change", bad, 0);
      press(0, 1'b1, "bounce_settle");

      // climb to 7, then reset in the middle of a debounce window
      for (int i = 0; i < 4; i++) press(0, 1'b1, "climb");
      chk("at_seven", bus.value, 7);
      @(negedge clk);
      bus.btn_up = 1'b1;
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_value", bus.value, 0);
      chk("async_reset_wrap", bus.wrap, 0);
      m[0] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      push_press(0, 1'b1);
      wait_change(0, "held_through_reset", n);
      repeat (HOLD - n) step();
      chk("held_through_reset_once", bus.value, 1);
      @(negedge clk);
      bus.btn_up = 1'b0;
      repeat (DEB + 4) step();

      // wrap in both directions
      press(0, 1'b0, "down_to_zero");
      press(0, 1'b0, "down_wrap");
      press(0, 1'b1, "up_wrap");
      press(0, 1'b1, "up_one");

      // simultaneous up and down
      @(negedge clk);
      set_btn(0, 1'b1, 1'b1);
      bad = 0;
      for (int i = 0; i < HOLD; i++) begin
         step();
         if (bus.value !== 4'(m[0]) || bus.wrap !== 1'b0) bad++;
      end
      chk("conflict_no_change", bad, 0);
      @(negedge clk);
      set_btn(0, 1'b0, 1'b0);
      repeat (DEB + 4) step();
      chk("conflict_released", bus.value, m[0]);

      // clr in the same cycle as an up pulse
      @(negedge clk);
      bus.btn_up = 1'b1;
      repeat (DEB + 2) step();
      chk("pre_clr_value", bus.value, m[0]);
      @(negedge clk);
      bus.clr = 1'b1;
      step();
      chk("clr_with_pulse_value", bus.value, 0);
      chk("clr_with_pulse_wrap", bus.wrap, 0);
      m[0] = 0;
      @(negedge clk);
      bus.clr = 1'b0;
      repeat (HOLD - DEB - 3) step();
      chk("clr_pulse_dropped", bus.value, 0);
      @(negedge clk);
      bus.btn_up = 1'b0;
      repeat (DEB + 4) step();
      chk("clr_released", bus.value, 0);

      // MAX=9 instance
      press(1, 1'b0, "max9_down_wrap");
      press(1, 1'b1, "max9_up_wrap");

`ifdef BTN_AUTOREPEAT_EN
      // held button autorepeats every REP cycles after the first press
      @(negedge clk);
      bus9.btn_up = 1'b1;
      push_press(1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         push_press(1, 1'b1);
         sb[sb.size() - 1].lat = REP;
      end
      for (int i = 0; i < 4; i++) wait_change(1, "repeat", n);
      @(negedge clk);
      bus9.btn_up = 1'b0;
      repeat (DEB + 4) step();
      chk("repeat_final", bus9.value, 4);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
